stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Central sequencer for the stopwatch. Consumes one-cycle button pulses from the
//   button-detector stage, arbitrates simultaneous presses, and runs a STOP/RUN/CLEAR FSM.
//   Drives the time-count datapath with a gated TICK_HZ enable pulse, a one-cycle clear
//   strobe and an optional display-hold flag. Sits between the button detectors and the
//   centisecond/second/minute counters.
// PARAMETERS
//   CLK_HZ   100_000_000  system clock frequency
//   TICK_HZ  100          tick rate to the time counters (centiseconds)
//   CNT_W    32           prescaler counter width; must hold CLK_HZ/TICK_HZ-1
// PORTS
//   clk             in   1  system clock, rising edge
//   reset           in   1  asynchronous, active-low reset (0 = reset)
//   i_btn_run_stop  in   1  one-cycle pulse: toggle run/stop
//   i_btn_clear     in   1  one-cycle pulse: clear time
//   i_btn_lap       in   1  one-cycle pulse: lap hold toggle (used only with LAP feature)
//   o_run           out  1  high while FSM in RUN
//   o_tick          out  1  one-cycle count-enable pulse at TICK_HZ, only while running
//   o_clear         out  1  one-cycle strobe: time counters reset to 0
//   o_disp_hold     out  1  display freezes last value while high
//   o_state         out  2  current FSM state encoding (debug / LEDs)
// BEHAVIOUR
// - Reset (reset==0, async): state=STOP, prescaler=0; o_run, o_tick, o_clear,
//   o_disp_hold = 0; o_state=2'd0. All outputs registered.
// - States: STOP=2'd0, RUN=2'd1, CLEAR=2'd2; 2'd3 illegal -> STOP next cycle.
// - STOP: clear -> CLEAR; else run_stop -> RUN; else hold. Clear beats run_stop.
// - RUN: run_stop -> STOP; clear ignored (must stop first); lap per CONFIGURATION.
// - CLEAR: lasts exactly 1 cycle, o_clear=1 during it, prescaler<=0, o_disp_hold<=0,
//   -> STOP unconditionally; all button pulses in this cycle dropped.
// - Latency: pulse sampled at edge N -> new state and o_run/o_clear visible after edge N+1.
// - Prescaler: DIV = CLK_HZ/TICK_HZ (integer, DIV>=2, else elaboration error).
//   Increments only in RUN; at DIV-1 wraps to 0 and o_tick=1 for the next cycle.
//   In STOP holds value (pause keeps fractional tick); zeroed only by CLEAR/reset.
//   From cleared state, first o_tick occurs DIV cycles after RUN entry.
// - Stop on the same edge the prescaler wraps: that tick is still issued (wrap wins).
// - Button pulses longer than 1 cycle: each high cycle is a separate press (no edge detect).
// CONFIGURATION
//   STOPWATCH_LAP_EN defined: i_btn_lap in RUN toggles o_disp_hold; lap in STOP sets
//   o_disp_hold=0; run_stop+lap same cycle -> run_stop acts, lap dropped; hold never
//   affects o_tick. Undefined: i_btn_lap ignored, o_disp_hold tied 0.
// STRUCTURE
//   stopwatch_pkg: state localparams (ST_STOP/ST_RUN/ST_CLEAR), function
//   calc_div(CLK_HZ,TICK_HZ).
//   Sub-module tick_prescaler (en, clr, o_tick; parameter DIV, CNT_W) instantiated
//   once; FSM, arbitration and lap logic stay in stopwatch_ctrl.
// TESTING  (bench uses CLK_HZ=1000, TICK_HZ=100 -> DIV=10)
//   1 reset low mid-RUN -> next sample o_run=0,o_tick=0,o_state=0; after release still STOP.
//   2 run_stop pulse, run 35 cycles -> exactly 3 o_tick pulses, first 10 cycles after entry.
//   3 RUN 14 cycles, stop, wait 20, run -> next o_tick 6 cycles after re-entry (pause kept).
//   4 STOP: clear+run_stop same cycle -> o_clear=1 one cycle, then STOP, o_run stays 0.
//   5 RUN: clear pulse -> ignored, o_clear=0, ticks continue every 10 cycles.
//   6 LAP_EN: RUN, lap -> o_disp_hold=1, ticks unaffected; lap -> 0; run_stop+lap -> STOP,
//     hold unchanged; without macro o_disp_hold constant 0.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch sequencer: FSM state encoding and tick divider helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_STOP    = 2'd0,
      ST_RUN     = 2'd1,
      ST_CLEAR   = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_e;

   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-pulse inputs and time-datapath controls of the stopwatch sequencer.
interface stopwatch_ctrl_if;
   logic       i_btn_run_stop;
   logic       i_btn_clear;
   logic       i_btn_lap;
   logic       o_run;
   logic       o_tick;
   logic       o_clear;
   logic       o_disp_hold;
   logic [1:0] o_state;

   modport master (
      output i_btn_run_stop, i_btn_clear, i_btn_lap,
      input  o_run, o_tick, o_clear, o_disp_hold, o_state
   );

   modport slave (
      input  i_btn_run_stop, i_btn_clear, i_btn_lap,
      output o_run, o_tick, o_clear, o_disp_hold, o_state
   );
endinterface

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every DIV enabled cycles.
// The count is held while disabled so a paused stopwatch keeps its fractional tick.
module tick_prescaler #(
   parameter int unsigned DIV   = 10,
   parameter int unsigned CNT_W = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic o_tick
);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   // Count enabled cycles, wrap at DIV-1 and flag the wrap for one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= CNT_ZERO;
         r_tick <= 1'b0;
      end else if (clr) begin
         r_cnt  <= CNT_ZERO;
         r_tick <= 1'b0;
      end else if (en) begin
         if (r_cnt == CNT_MAX) begin
            r_cnt  <= CNT_ZERO;
            r_tick <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_tick <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign o_tick = r_tick;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: arbitrates button pulses, runs the STOP/RUN/CLEAR FSM and gates ticks.
// Define STOPWATCH_LAP_EN to enable the lap display-hold toggle; otherwise o_disp_hold is 0.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 100,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   stopwatch_ctrl_if.slave  bus
);
   localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

   if (DIV < 2 || CNT_W < $clog2(DIV)) begin : g_div_check
      $error("stopwatch_ctrl: DIV must be >= 2 and fit in CNT_W bits");
   end

   state_e     r_state;
   state_e     w_state_next;
   logic       w_run;
   logic       w_clear;
   logic [1:0] w_state_out;
   logic       w_presc_en;
   logic       w_presc_clr;
   logic       w_tick;
   logic       r_run;
   logic       r_tick;
   logic       r_clear;
   logic [1:0] r_state_out;

   assign w_presc_en  = (r_state == ST_RUN);
   assign w_presc_clr = (r_state == ST_CLEAR);

   tick_prescaler #(
      .DIV   (DIV),
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .en     (w_presc_en),
      .clr    (w_presc_clr),
      .o_tick (w_tick)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_STOP;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: clear beats run_stop in STOP, clear is ignored in RUN
   always_comb begin
      w_state_next = ST_STOP;
      case (r_state)
         ST_STOP: begin
            if (bus.i_btn_clear) begin
               w_state_next = ST_CLEAR;
            end else if (bus.i_btn_run_stop) begin
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_STOP;
            end
         end
         ST_RUN: begin
            if (bus.i_btn_run_stop) begin
               w_state_next = ST_STOP;
            end else begin
               w_state_next = ST_RUN;
            end
         end
         ST_CLEAR: w_state_next = ST_STOP;
         default:  w_state_next = ST_STOP;
      endcase
   end

   // Output decode from the current state
   always_comb begin
      w_run       = 1'b0;
      w_clear     = 1'b0;
      w_state_out = r_state;
      case (r_state)
         ST_RUN:   w_run   = 1'b1;
         ST_CLEAR: w_clear = 1'b1;
         default: begin
            w_run   = 1'b0;
            w_clear = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_run       <= 1'b0;
         r_tick      <= 1'b0;
         r_clear     <= 1'b0;
         r_state_out <= 2'd0;
      end else begin
         r_run       <= w_run;
         r_tick      <= w_tick;
         r_clear     <= w_clear;
         r_state_out <= w_state_out;
      end
   end

   assign bus.o_run   = r_run;
   assign bus.o_tick  = r_tick;
   assign bus.o_clear = r_clear;
   assign bus.o_state = r_state_out;

`ifdef STOPWATCH_LAP_EN
   logic r_hold;
   logic w_hold_next;
   logic r_disp_hold;

   // Lap toggles hold in RUN unless run_stop arrives in the same cycle
   always_comb begin
      w_hold_next = r_hold;
      case (r_state)
         ST_RUN: begin
            if (bus.i_btn_run_stop) begin
               w_hold_next = r_hold;
            end else if (bus.i_btn_lap) begin
               w_hold_next = ~r_hold;
            end else begin
               w_hold_next = r_hold;
            end
         end
         ST_STOP: begin
            if (bus.i_btn_lap) begin
               w_hold_next = 1'b0;
            end else begin
               w_hold_next = r_hold;
            end
         end
         ST_CLEAR: w_hold_next = 1'b0;
         default:  w_hold_next = r_hold;
      endcase
   end

   // Hold state and its registered output copy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold      <= 1'b0;
         r_disp_hold <= 1'b0;
      end else begin
         r_hold      <= w_hold_next;
         r_disp_hold <= r_hold;
      end
   end

   assign bus.o_disp_hold = r_disp_hold;
`else
   logic w_unused_lap;
   assign w_unused_lap    = bus.i_btn_lap;
   assign bus.o_disp_hold = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a behavioural model queues expected outputs per cycle,
// a negedge monitor pops and compares; directed scenarios also check tick spacing and hold.
module tb_stopwatch_ctrl;
   localparam int unsigned CLK_HZ  = 1000;
   localparam int unsigned TICK_HZ = 100;
   localparam int          DIV     = 10;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP = 1'b1;
`else
   localparam bit LAP = 1'b0;
`endif

   typedef struct {
      bit       run;
      bit       tick;
      bit       clear;
      bit       hold;
      bit [1:0] st;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   stopwatch_ctrl_if bus();

   stopwatch_ctrl #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ),
      .CNT_W   (8)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   exp_t pend;
   exp_t mon_e;
   bit   have_pend = 1'b0;

   // reference model: mode 0 = stopped, 1 = running, 2 = clearing
   int   m_mode;
   int   m_frac;
   bit   m_hold;

   logic       s_run, s_tick, s_clear, s_hold;
   logic [1:0] s_state;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   // One clock edge of the stopwatch rules; result is what the outputs show one edge later
   task automatic model_edge(input bit rs, input bit cl, input bit lp);
      bit wrap;
      wrap = (m_mode == 1) && (m_frac == DIV - 1);
      if (m_mode == 1) m_frac = (m_frac + 1) % DIV;
      else if (m_mode == 2) m_frac = 0;
      if (m_mode == 2) begin
         m_mode = 0;
         m_hold = 1'b0;
      end else if (m_mode == 1) begin
         if (rs) m_mode = 0;
         else if (lp && LAP) m_hold = !m_hold;
      end else begin
         if (lp && LAP) m_hold = 1'b0;
         if (cl) m_mode = 2;
         else if (rs) m_mode = 1;
      end
      pend.run   = (m_mode == 1);
      pend.clear = (m_mode == 2);
      pend.tick  = wrap;
      pend.hold  = m_hold;
      pend.st    = 2'(m_mode);
   endtask

   task automatic step(input bit rs, input bit cl, input bit lp);
      bus.i_btn_run_stop = rs;
      bus.i_btn_clear    = cl;
      bus.i_btn_lap      = lp;
      @(posedge clk);
      if (have_pend) exp_q.push_back(pend);
      model_edge(rs, cl, lp);
      have_pend = 1'b1;
      #1;
      s_run   = bus.o_run;
      s_tick  = bus.o_tick;
      s_clear = bus.o_clear;
      s_hold  = bus.o_disp_hold;
      s_state = bus.o_state;
   endtask

   task automatic do_reset();
      bus.i_btn_run_stop = 1'b0;
      bus.i_btn_clear    = 1'b0;
      bus.i_btn_lap      = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_run", bus.o_run, 0);
      chk("rst_tick", bus.o_tick, 0);
      chk("rst_clear", bus.o_clear, 0);
      chk("rst_hold", bus.o_disp_hold, 0);
      chk("rst_state", bus.o_state, 0);
      exp_q.delete();
      m_mode = 0;
      m_frac = 0;
      m_hold = 1'b0;
      pend   = '{run: 1'b0, tick: 1'b0, clear: 1'b0, hold: 1'b0, st: 2'd0};
      have_pend = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("sb_run", bus.o_run, mon_e.run);
         chk("sb_tick", bus.o_tick, mon_e.tick);
         chk("sb_clear", bus.o_clear, mon_e.clear);
         chk("sb_hold", bus.o_disp_hold, mon_e.hold);
         chk("sb_state", bus.o_state, mon_e.st);
      end
   end

   initial begin
      int first;
      int ticks;
      int clears;
      int runs;
      int prev;
      do_reset();

      // first tick DIV cycles after RUN entry, three ticks in 35 cycles
      step(1'b1, 1'b0, 1'b0);
      first = -1;
      ticks = 0;
      for (int i = 0; i < 35; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (s_tick) begin
            ticks++;
            if (first < 0) first = i;
         end
      end
      chk("t2_ticks", ticks, 3);
      chk("t2_first", first, 10);

      // clear beats run_stop when stopped
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      clears = 0;
      runs   = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0);
         clears += int'(s_clear);
         runs   += int'(s_run);
      end
      chk("t4_clears", clears, 1);
      chk("t4_runs", runs, 0);
      chk("t4_state", s_state, 0);

      // pause keeps the fractional tick
      step(1'b1, 1'b0, 1'b0);
      repeat (13) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      repeat (20) step(1'b0, 1'b0, 1'b0);
      chk("t3_stopped", s_run, 0);
      step(1'b1, 1'b0, 1'b0);
      first = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (s_tick && first < 0) first = i;
      end
      chk("t3_first", first, 6);

      // clear while running is ignored and ticks stay 10 apart
      step(1'b0, 1'b1, 1'b0);
      clears = 0;
      prev   = -1;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b0, 1'b0);
         clears += int'(s_clear);
         if (s_tick) begin
            if (prev >= 0) chk("t5_gap", i - prev, 10);
            prev = i;
         end
      end
      chk("t5_clears", clears, 0);
      chk("t5_run", s_run, 1);

      // lap hold toggling
      step(1'b0, 1'b0, 1'b1);
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b0);
         ticks += int'(s_tick);
      end
      chk("t6_hold_on", s_hold, 32'(LAP));
      chk("t6_ticks", ticks, 1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("t6_hold_off", s_hold, 0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("t6_hold_on2", s_hold, 32'(LAP));
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("t6_stop_run", s_run, 0);
      chk("t6_stop_hold", s_hold, 32'(LAP));
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("t6_stop_lap", s_hold, 0);

      // asynchronous reset in the middle of RUN
      step(1'b1, 1'b0, 1'b0);
      repeat (7) step(1'b0, 1'b0, 1'b0);
      chk("t1_running", s_run, 1);
      do_reset();
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("t1_state", s_state, 0);
      chk("t1_run", s_run, 0);

      // randomized presses, including multi-cycle pulses
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
      end

      step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
